// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU issue sequencer: width defaults, ALU select
// codes, FSM state encoding and a saturating-increment helper.
package alu_sequencer_pkg;

  localparam int ALU_DATA_W = 8;
  localparam int ALU_SEL_W  = 3;

  localparam logic [ALU_SEL_W-1:0] ALU_SEL_ADD = 3'b000;
  localparam logic [ALU_SEL_W-1:0] ALU_SEL_OR  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETTLE = 2'b01,
    ST_RESP   = 2'b10
  } seq_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request / ALU operand / response bundle of the ALU issue sequencer.
// slave = sequencer side, master = control + ALU side.
interface alu_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3,
  parameter int TAG_W  = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [SEL_W-1:0]  req_sel;
  logic [TAG_W-1:0]  req_tag;

  logic [DATA_W-1:0] alu_in1;
  logic [DATA_W-1:0] alu_in2;
  logic [SEL_W-1:0]  alu_sel;
  logic [DATA_W-1:0] alu_out;
  logic              alu_z;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic [TAG_W-1:0]  rsp_tag;

  logic              busy;

  modport slave (
    input  req_valid, req_a, req_b, req_sel, req_tag,
    output req_ready,
    output alu_in1, alu_in2, alu_sel,
    input  alu_out, alu_z,
    output rsp_valid, rsp_result, rsp_zero, rsp_tag,
    input  rsp_ready,
    output busy
  );

  modport master (
    output req_valid, req_a, req_b, req_sel, req_tag,
    input  req_ready,
    input  alu_in1, alu_in2, alu_sel,
    output alu_out, alu_z,
    input  rsp_valid, rsp_result, rsp_zero, rsp_tag,
    output rsp_ready,
    input  busy
  );

endinterface

// File: rtl/alu_seq_stats.sv
// Saturating completed-response and zero-result counters for alu_sequencer.
// Only exists when ALU_SEQ_STATS_EN is defined.
`ifdef ALU_SEQ_STATS_EN
module alu_seq_stats
  import alu_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        rsp_fire_i,
  input  logic        rsp_zero_i,
  output logic [15:0] stat_ops_o,
  output logic [15:0] stat_zero_o
);

  logic [15:0] ops_q, ops_d;
  logic [15:0] zero_q, zero_d;

  always_comb begin
    ops_d  = ops_q;
    zero_d = zero_q;
    if (rsp_fire_i) begin
      ops_d = sat_inc16(ops_q);
      if (rsp_zero_i) begin
        zero_d = sat_inc16(zero_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ops_q  <= '0;
      zero_q <= '0;
    end else begin
      ops_q  <= ops_d;
      zero_q <= zero_d;
    end
  end

  assign stat_ops_o  = ops_q;
  assign stat_zero_o = zero_q;

endmodule
`endif

// File: rtl/alu_sequencer.sv
// Issues one operation to a combinational ALU, waits SETTLE_CYCLES edges, then
// returns the captured result/zero flag with its tag. ALU_SEQ_STATS_EN adds counters.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int DATA_W        = ALU_DATA_W,
  parameter int SEL_W         = ALU_SEL_W,
  parameter int TAG_W         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  alu_sequencer_if.slave bus
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0] stat_ops,
  output logic [15:0] stat_zero
`endif
);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("alu_sequencer: SETTLE_CYCLES must be >= 1");
  end

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] in1_q, in1_d;
  logic [DATA_W-1:0] in2_q, in2_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;

  logic req_ready;
  logic accept;

  // Ready depends on state and rsp_ready only, so a caller may wait on it.
  assign req_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && bus.rsp_ready);
  assign accept    = bus.req_valid && req_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    in1_d        = in1_q;
    in2_d        = in2_q;
    sel_d        = sel_q;
    tag_d        = tag_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_tag_d    = rsp_tag_q;

    case (state_q)
      ST_IDLE: begin
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          rsp_result_d = bus.alu_out;
          rsp_zero_d   = bus.alu_z;
          rsp_tag_d    = tag_q;
          rsp_valid_d  = 1'b1;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A retiring response and a new request may share the same edge.
    if (accept) begin
      in1_d   = bus.req_a;
      in2_d   = bus.req_b;
      sel_d   = bus.req_sel;
      tag_d   = bus.req_tag;
      cnt_d   = CNT_LOAD;
      state_d = ST_SETTLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      in1_q        <= '0;
      in2_q        <= '0;
      sel_q        <= '0;
      tag_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      in1_q        <= in1_d;
      in2_q        <= in2_d;
      sel_q        <= sel_d;
      tag_q        <= tag_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_tag_q    <= rsp_tag_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.alu_in1    = in1_q;
  assign bus.alu_in2    = in2_q;
  assign bus.alu_sel    = sel_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign bus.busy       = (state_q != ST_IDLE);

`ifdef ALU_SEQ_STATS_EN
  alu_seq_stats u_stats (
    .clk         (clk),
    .reset       (reset),
    .rsp_fire_i  (rsp_valid_q && bus.rsp_ready),
    .rsp_zero_i  (rsp_zero_q),
    .stat_ops_o  (stat_ops),
    .stat_zero_o (stat_zero)
  );
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: two instances (settle 1 and 3) checked every cycle
// against a transaction-level model, plus directed literal scenarios.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  localparam int DW = 8;
  localparam int SW = 3;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_sequencer_if #(.DATA_W(DW), .SEL_W(SW), .TAG_W(TW)) bus1 ();
  alu_sequencer_if #(.DATA_W(DW), .SEL_W(SW), .TAG_W(TW)) bus3 ();

  logic          rq_v [2];
  logic [DW-1:0] rq_a [2];
  logic [DW-1:0] rq_b [2];
  logic [SW-1:0] rq_s [2];
  logic [TW-1:0] rq_t [2];
  logic          rs_r [2];

  function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [SW-1:0] s);
    case (s)
      3'b000:  return a + b;
      3'b100:  return a | b;
      default: return a - b;
    endcase
  endfunction

  assign bus1.req_valid = rq_v[0];
  assign bus1.req_a     = rq_a[0];
  assign bus1.req_b     = rq_b[0];
  assign bus1.req_sel   = rq_s[0];
  assign bus1.req_tag   = rq_t[0];
  assign bus1.rsp_ready = rs_r[0];
  assign bus1.alu_out   = alu_f(bus1.alu_in1, bus1.alu_in2, bus1.alu_sel);
  assign bus1.alu_z     = (bus1.alu_out == '0);

  assign bus3.req_valid = rq_v[1];
  assign bus3.req_a     = rq_a[1];
  assign bus3.req_b     = rq_b[1];
  assign bus3.req_sel   = rq_s[1];
  assign bus3.req_tag   = rq_t[1];
  assign bus3.rsp_ready = rs_r[1];
  assign bus3.alu_out   = alu_f(bus3.alu_in1, bus3.alu_in2, bus3.alu_sel);
  assign bus3.alu_z     = (bus3.alu_out == '0);

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] st_ops1, st_zero1, st_ops3, st_zero3;
`endif

  alu_sequencer #(.DATA_W(DW), .SEL_W(SW), .TAG_W(TW), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
`ifdef ALU_SEQ_STATS_EN
    , .stat_ops(st_ops1), .stat_zero(st_zero1)
`endif
  );

  alu_sequencer #(.DATA_W(DW), .SEL_W(SW), .TAG_W(TW), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3)
`ifdef ALU_SEQ_STATS_EN
    , .stat_ops(st_ops3), .stat_zero(st_zero3)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: an accepted op owes its response exactly
  // 'settle' edges later; responses leave on a rsp_ready handshake.
  int            settle_c [2] = '{1, 3};
  int            cyc = 0;
  logic          m_pend [2];
  logic          m_rv [2];
  logic          m_fresh [2];
  int            m_acc [2];
  logic [DW-1:0] m_in1 [2];
  logic [DW-1:0] m_in2 [2];
  logic [SW-1:0] m_sel [2];
  logic [TW-1:0] m_tagp [2];
  logic [DW-1:0] m_res [2];
  logic          m_zero [2];
  logic [TW-1:0] m_tag [2];
  int            m_ops [2];
  int            m_zc [2];
  logic          fire_req [2];

  function automatic logic m_ready(input int i);
    return (!m_pend[i] && !m_rv[i]) || (m_rv[i] && rs_r[i]);
  endfunction

  task automatic model_step(input int i);
    logic rdy;
    fire_req[i] = 1'b0;
    if (reset) begin
      m_pend[i] = 0; m_rv[i] = 0; m_fresh[i] = 1; m_acc[i] = 0;
      m_in1[i] = 0; m_in2[i] = 0; m_sel[i] = 0; m_tagp[i] = 0;
      m_res[i] = 0; m_zero[i] = 0; m_tag[i] = 0; m_ops[i] = 0; m_zc[i] = 0;
    end else begin
      rdy = m_ready(i);
      fire_req[i] = rq_v[i] && rdy;
      if (m_rv[i] && rs_r[i]) begin
        m_rv[i] = 0;
        if (m_ops[i] < 65535) m_ops[i]++;
        if (m_zero[i] && m_zc[i] < 65535) m_zc[i]++;
      end
      if (m_pend[i] && (cyc - m_acc[i] == settle_c[i])) begin
        m_res[i]  = alu_f(m_in1[i], m_in2[i], m_sel[i]);
        m_zero[i] = (m_res[i] == '0);
        m_tag[i]  = m_tagp[i];
        m_rv[i] = 1; m_pend[i] = 0; m_fresh[i] = 0;
      end
      if (fire_req[i]) begin
        m_pend[i] = 1; m_acc[i] = cyc;
        m_in1[i] = rq_a[i]; m_in2[i] = rq_b[i]; m_sel[i] = rq_s[i]; m_tagp[i] = rq_t[i];
      end
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
    cyc++;
  end

  task automatic cycle_check(input int i, input logic rdy, input logic bsy, input logic rv,
                             input logic [DW-1:0] in1, input logic [DW-1:0] in2,
                             input logic [SW-1:0] sel, input logic [DW-1:0] res,
                             input logic z, input logic [TW-1:0] tg);
    string p;
    p = (i == 0) ? "s1" : "s3";
    chk({p, ".req_ready"}, 32'(rdy), 32'(m_ready(i)));
    chk({p, ".busy"}, 32'(bsy), 32'(m_pend[i] || m_rv[i]));
    chk({p, ".rsp_valid"}, 32'(rv), 32'(m_rv[i]));
    chk({p, ".alu_in1"}, 32'(in1), 32'(m_in1[i]));
    chk({p, ".alu_in2"}, 32'(in2), 32'(m_in2[i]));
    chk({p, ".alu_sel"}, 32'(sel), 32'(m_sel[i]));
    if (m_rv[i] || m_fresh[i]) begin
      chk({p, ".rsp_result"}, 32'(res), 32'(m_res[i]));
      chk({p, ".rsp_zero"}, 32'(z), 32'(m_zero[i]));
      chk({p, ".rsp_tag"}, 32'(tg), 32'(m_tag[i]));
    end
  endtask

  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      cycle_check(0, bus1.req_ready, bus1.busy, bus1.rsp_valid, bus1.alu_in1, bus1.alu_in2,
                  bus1.alu_sel, bus1.rsp_result, bus1.rsp_zero, bus1.rsp_tag);
      cycle_check(1, bus3.req_ready, bus3.busy, bus3.rsp_valid, bus3.alu_in1, bus3.alu_in2,
                  bus3.alu_sel, bus3.rsp_result, bus3.rsp_zero, bus3.rsp_tag);
`ifdef ALU_SEQ_STATS_EN
      chk("s1.stat_ops", 32'(st_ops1), 32'(m_ops[0]));
      chk("s1.stat_zero", 32'(st_zero1), 32'(m_zc[0]));
      chk("s3.stat_ops", 32'(st_ops3), 32'(m_ops[1]));
      chk("s3.stat_zero", 32'(st_zero3), 32'(m_zc[1]));
`endif
    end
  end

  typedef struct {
    logic [DW-1:0] res;
    logic          z;
    logic [TW-1:0] tag;
    int            c;
  } rsp_t;
  rsp_t log1[$];
  rsp_t log3[$];

  always @(negedge clk) begin
    if (bus1.rsp_valid === 1'b1 && rs_r[0])
      log1.push_back('{res: bus1.rsp_result, z: bus1.rsp_zero, tag: bus1.rsp_tag, c: cyc});
    if (bus3.rsp_valid === 1'b1 && rs_r[1])
      log3.push_back('{res: bus3.rsp_result, z: bus3.rsp_zero, tag: bus3.rsp_tag, c: cyc});
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [SW-1:0] s, input logic [TW-1:0] t);
    logic ok;
    ok = 1'b0;
    rq_a[i] = a; rq_b[i] = b; rq_s[i] = s; rq_t[i] = t; rq_v[i] = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (fire_req[i]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("send_accepted", 32'(ok), 32'd1);
    rq_v[i] = 1'b0;
  endtask

  task automatic drain(input int i);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (!m_pend[i] && !m_rv[i] && !rq_v[i]) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("drain_idle", 32'(ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rq_v = '{0, 0}; rq_a = '{0, 0}; rq_b = '{0, 0}; rq_s = '{0, 0}; rq_t = '{0, 0};
    rs_r = '{1, 1};

    // 1: reset held three cycles
    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("t1.req_ready", 32'(bus1.req_ready), 32'd1);
    chk("t1.busy", 32'(bus1.busy), 32'd0);
    chk("t1.rsp_valid", 32'(bus1.rsp_valid), 32'd0);
    chk("t1.alu_lines", {16'(bus1.alu_in1), 8'(bus1.alu_in2), 8'(bus1.alu_sel)}, 32'd0);

    // 2: single op, settle 1
    send(0, 8'd2, 8'd4, ALU_SEL_ADD, 4'd3);
    chk("t2.alu_in1", 32'(bus1.alu_in1), 32'd2);
    chk("t2.alu_in2", 32'(bus1.alu_in2), 32'd4);
    chk("t2.rsp_valid_early", 32'(bus1.rsp_valid), 32'd0);
    tick();
    chk("t2.rsp_valid", 32'(bus1.rsp_valid), 32'd1);
    chk("t2.result", 32'(bus1.rsp_result), 32'd6);
    chk("t2.zero", 32'(bus1.rsp_zero), 32'd0);
    chk("t2.tag", 32'(bus1.rsp_tag), 32'd3);
    tick();
    chk("t2.idle_busy", 32'(bus1.busy), 32'd0);
    chk("t2.idle_rsp_valid", 32'(bus1.rsp_valid), 32'd0);

    // 3: back-to-back requests
    log1.delete();
    send(0, 8'd5, 8'd3, ALU_SEL_ADD, 4'd5);
    send(0, 8'd1, 8'd3, ALU_SEL_OR, 4'd6);
    drain(0);
    chk("t3.count", 32'(log1.size()), 32'd2);
    if (log1.size() == 2) begin
      chk("t3.res0", 32'(log1[0].res), 32'd8);
      chk("t3.tag0", 32'(log1[0].tag), 32'd5);
      chk("t3.res1", 32'(log1[1].res), 32'd3);
      chk("t3.tag1", 32'(log1[1].tag), 32'd6);
      chk("t3.spacing", 32'(log1[1].c - log1[0].c), 32'd2);
    end

    // 4: back-pressure with a pending request
    rs_r[0] = 1'b0;
    send(0, 8'd0, 8'd0, ALU_SEL_ADD, 4'd9);
    tick();
    rq_a[0] = 8'd7; rq_b[0] = 8'd1; rq_s[0] = ALU_SEL_ADD; rq_t[0] = 4'd10; rq_v[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("t4.rsp_valid", 32'(bus1.rsp_valid), 32'd1);
      chk("t4.result", 32'(bus1.rsp_result), 32'd0);
      chk("t4.zero", 32'(bus1.rsp_zero), 32'd1);
      chk("t4.req_ready", 32'(bus1.req_ready), 32'd0);
      chk("t4.alu_in1_held", 32'(bus1.alu_in1), 32'd0);
      tick();
    end
    rs_r[0] = 1'b1;
    tick();
    rq_v[0] = 1'b0;
    chk("t4.accept_alu_in1", 32'(bus1.alu_in1), 32'd7);
    tick();
    chk("t4.result2", 32'(bus1.rsp_result), 32'd8);
    drain(0);

    // 5: reset during SETTLE on the settle-3 instance
    log3.delete();
    send(1, 8'd9, 8'd9, ALU_SEL_ADD, 4'd2);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5.busy", 32'(bus3.busy), 32'd0);
    chk("t5.alu_in1", 32'(bus3.alu_in1), 32'd0);
    for (int k = 0; k < 6; k++) begin
      chk("t5.no_rsp", 32'(bus3.rsp_valid), 32'd0);
      tick();
    end
    send(1, 8'd3, 8'd4, ALU_SEL_ADD, 4'd7);
    drain(1);
    chk("t5.count", 32'(log3.size()), 32'd1);
    if (log3.size() == 1) begin
      chk("t5.result", 32'(log3[0].res), 32'd7);
      chk("t5.tag", 32'(log3[0].tag), 32'd7);
    end

`ifdef ALU_SEQ_STATS_EN
    // 6: statistics counters
    reset = 1'b1;
    tick();
    reset = 1'b0;
    send(0, 8'd0, 8'd0, ALU_SEL_ADD, 4'd1);
    send(0, 8'd1, 8'd2, ALU_SEL_ADD, 4'd2);
    send(0, 8'd0, 8'd0, ALU_SEL_OR, 4'd3);
    send(0, 8'd3, 8'd0, ALU_SEL_OR, 4'd4);
    drain(0);
    chk("t6.stat_ops", 32'(st_ops1), 32'd4);
    chk("t6.stat_zero", 32'(st_zero1), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6.stat_ops_rst", 32'(st_ops1), 32'd0);
    chk("t6.stat_zero_rst", 32'(st_zero1), 32'd0);
`endif

    // Random traffic on both instances, one mid-run reset
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (rq_v[i] && fire_req[i]) rq_v[i] = 1'b0;
        if (!rq_v[i] && $urandom_range(0, 2) == 0) begin
          rq_a[i] = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
          rq_b[i] = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
          rq_s[i] = SW'($urandom_range(0, 7));
          rq_t[i] = TW'($urandom);
          rq_v[i] = 1'b1;
        end
        rs_r[i] = ($urandom_range(0, 3) != 0);
      end
      reset = (c == 400);
      tick();
    end
    reset = 1'b0;
    rs_r = '{1, 1};
    tick();
    for (int i = 0; i < 2; i++) begin
      if (rq_v[i] && fire_req[i]) rq_v[i] = 1'b0;
    end
    for (int k = 0; k < 20 && (rq_v[0] || rq_v[1]); k++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (rq_v[i] && fire_req[i]) rq_v[i] = 1'b0;
      end
    end
    rq_v = '{0, 0};
    drain(0);
    drain(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
